// File: rtl/mw_pipe_stage.sv
// mw_pipe_stage
//   Elastic MEM->WB pipeline register for the writeback bundle
//   (RegWrite, MemtoReg, ReadData, ALUOut, WA3). It uses a valid/ready
//   handshake on both sides and supports a synchronous bubble flush.
//
//   Build option: define MW_PIPE_SKID_EN to add a one-entry skid register.
//   In that build ReadyM is registered (it is !skid_valid), and the stage
//   keeps full throughput across single-cycle ReadyW drops. Without the
//   macro the stage holds a single beat, and ReadyM = ReadyW | ~ValidW
//   (combinational, forced low while Reset is high).
//
// Ports
//   CLK, Reset            clock; asynchronous active-high reset
//   FlushM                synchronous flush, drops every held beat
//   ValidM / ReadyM       upstream handshake
//   RegWriteM, MemtoRegM  upstream control bits
//   ReadDataM, ALUOutM    upstream data (DATA_W)
//   WA3M                  upstream destination register (ADDR_W)
//   ValidW / ReadyW       downstream handshake
//   RegWriteW ... WA3W    registered writeback bundle; RegWriteW is 0
//                         whenever ValidW is 0
module mw_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              FlushM,
    input  logic              ValidM,
    output logic              ReadyM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [DATA_W-1:0] ReadDataM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [ADDR_W-1:0] WA3M,
    output logic              ValidW,
    input  logic              ReadyW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [ADDR_W-1:0] WA3W
);

    // Main register (drives the W outputs)
    logic              vld_p1;
    logic              regwrite_p1;
    logic              memtoreg_p1;
    logic [DATA_W-1:0] readdata_p1;
    logic [DATA_W-1:0] aluout_p1;
    logic [ADDR_W-1:0] wa3_p1;

    logic accept_m;   // upstream handshake this cycle
    logic main_free;  // main is empty or its beat drains this cycle

    assign main_free = ~vld_p1 | ReadyW;
    assign accept_m  = ValidM & ReadyM;

`ifdef MW_PIPE_SKID_EN
    // Skid register (holds the beat accepted while main is stalled)
    logic              vld_p0;
    logic              regwrite_p0;
    logic              memtoreg_p0;
    logic [DATA_W-1:0] readdata_p0;
    logic [DATA_W-1:0] aluout_p0;
    logic [ADDR_W-1:0] wa3_p0;
    logic              rdy_q;

    // rdy_q tracks !vld_p0, but it resets low, so no beat is taken
    // until the first edge after Reset is released.
    assign ReadyM = rdy_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            memtoreg_p0 <= 1'b0;
            readdata_p0 <= '0;
            aluout_p0   <= '0;
            wa3_p0      <= '0;
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            readdata_p1 <= '0;
            aluout_p1   <= '0;
            wa3_p1      <= '0;
            rdy_q       <= 1'b0;
        end else if (FlushM) begin
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            rdy_q       <= 1'b1;
        end else if (main_free) begin
            if (vld_p0) begin
                // The older skid beat goes first. ReadyM is low while the
                // skid is full, so no new beat competes in this cycle.
                vld_p1      <= 1'b1;
                regwrite_p1 <= regwrite_p0;
                memtoreg_p1 <= memtoreg_p0;
                readdata_p1 <= readdata_p0;
                aluout_p1   <= aluout_p0;
                wa3_p1      <= wa3_p0;
                vld_p0      <= 1'b0;
                regwrite_p0 <= 1'b0;
            end else begin
                vld_p1      <= accept_m;
                regwrite_p1 <= accept_m & RegWriteM;
                if (accept_m) begin
                    memtoreg_p1 <= MemtoRegM;
                    readdata_p1 <= ReadDataM;
                    aluout_p1   <= ALUOutM;
                    wa3_p1      <= WA3M;
                end
            end
            rdy_q <= 1'b1;
        end else if (accept_m) begin
            vld_p0      <= 1'b1;
            regwrite_p0 <= RegWriteM;
            memtoreg_p0 <= MemtoRegM;
            readdata_p0 <= ReadDataM;
            aluout_p0   <= ALUOutM;
            wa3_p0      <= WA3M;
            rdy_q       <= 1'b0;
        end
    end
`else
    assign ReadyM = ~Reset & main_free;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            readdata_p1 <= '0;
            aluout_p1   <= '0;
            wa3_p1      <= '0;
        end else if (FlushM) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
        end else if (main_free) begin
            vld_p1      <= accept_m;
            regwrite_p1 <= accept_m & RegWriteM;
            if (accept_m) begin
                memtoreg_p1 <= MemtoRegM;
                readdata_p1 <= ReadDataM;
                aluout_p1   <= ALUOutM;
                wa3_p1      <= WA3M;
            end
        end
    end
`endif

    assign ValidW    = vld_p1;
    assign RegWriteW = regwrite_p1;
    assign MemtoRegW = memtoreg_p1;
    assign ReadDataW = readdata_p1;
    assign ALUOutW   = aluout_p1;
    assign WA3W      = wa3_p1;

endmodule
